// File: rtl/norm_pkg.sv
// -----------------------------------------------------------------------------
// norm_pkg
//
// Shared definitions for the sequential normalizer (norm_seq) and its
// combinational stage (norm_stage).
//
// Contents:
//   norm_state_t  - 2-bit state word for the normalizer FSM
//   NORM_IDLE     - waiting for a start request
//   NORM_RUN      - one binary-search stage per clock, MSB stage first
//   NORM_DONE     - result valid, one-cycle done pulse
//   norm_mode_t   - operand interpretation captured with the operand
//   NORM_UNSIGNED - shift until the MSB is one
//   NORM_SIGNED   - shift until the two top bits differ
// -----------------------------------------------------------------------------
package norm_pkg;

   typedef logic [1:0] norm_state_t;

   localparam norm_state_t NORM_IDLE = 2'd0;
   localparam norm_state_t NORM_RUN  = 2'd1;
   localparam norm_state_t NORM_DONE = 2'd2;

   typedef logic norm_mode_t;

   localparam norm_mode_t NORM_UNSIGNED = 1'b0;
   localparam norm_mode_t NORM_SIGNED   = 1'b1;

endpackage : norm_pkg

// File: rtl/norm_stage.sv
// -----------------------------------------------------------------------------
// norm_stage
//
// One binary-search step of the normalizer, purely combinational. A single
// instance is time-shared across all stages; the stage is picked by k, giving
// a step of s = 2^k bit positions.
//
// Ports:
//   v       in   WIDTH        partially normalized value
//   k       in   SHIFT_WIDTH  stage index, step s = 2^k
//   sgn     in   1            NORM_UNSIGNED / NORM_SIGNED
//   hit     out  1            the top bits allow a shift by s
//   v_next  out  WIDTH        v << s on a hit, otherwise v
//
// Hit rules:
//   unsigned: the top s bits of v are all zero
//   signed:   the top s+1 bits of v all equal the sign bit, so the shift
//             leaves the sign unchanged
// -----------------------------------------------------------------------------
module norm_stage
   import norm_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SHIFT_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]       v,
   input  logic [SHIFT_WIDTH-1:0] k,
   input  logic                   sgn,
   output logic                   hit,
   output logic [WIDTH-1:0]       v_next
);

   int step;

   always_comb begin
      // NOTE: every signal written here gets a value before any condition,
      // so no path can leave one unassigned and infer a latch.
      step = 1 << k;
      hit  = 1'b1;

      // Scan from the MSB down. Bit WIDTH-1-i belongs to the inspected window
      // when i < s (unsigned) or i <= s (signed, one extra bit for the sign).
      for (int i = 0; i < WIDTH; i++) begin
         if (sgn == NORM_SIGNED) begin
            if ((i <= step) && (v[WIDTH-1-i] != v[WIDTH-1])) begin
               hit = 1'b0;
            end
         end else begin
            if ((i < step) && v[WIDTH-1-i]) begin
               hit = 1'b0;
            end
         end
      end

      v_next = hit ? (v << step) : v;
   end

endmodule : norm_stage

// File: rtl/norm_seq.sv
// -----------------------------------------------------------------------------
// norm_seq
//
// Multi-cycle normalizer for the integer ALU, the inverse of the left barrel
// shifter. For operand x it finds count such that x << count is normalized
// and returns both. A binary search runs one shift stage per clock, largest
// stage first, behind a start/busy/done handshake.
//
// Ports:
//   clk       in   1            clock, rising edge
//   rst       in   1            synchronous reset, active-high
//   start     in   1            request, honoured only when not busy
//   x         in   WIDTH        operand, captured on the accepted start edge
//   sgn       in   1            0 = unsigned, 1 = signed, captured with x
//   busy      out  1            high while the search runs
//   done      out  1            one-cycle pulse when y/count become valid
//   y         out  WIDTH        normalized value, held until the next result
//   count     out  SHIFT_WIDTH  shift amount applied, held with y
//   negative  out  1            y[WIDTH-1]
//   zero      out  1            y is all zeros
//   cout      out  1            always 0
//   overflow  out  1            always 0, normalizing never changes the sign
//
// Timing: start high in cycle 0 -> busy in cycles 1..SHIFT_WIDTH -> done in
// cycle SHIFT_WIDTH+1. A start in the done cycle begins the next operation
// with no idle bubble.
// -----------------------------------------------------------------------------
module norm_seq
   import norm_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SHIFT_WIDTH = $clog2(WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [WIDTH-1:0]       x,
   input  logic                   sgn,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       y,
   output logic [SHIFT_WIDTH-1:0] count,
   output logic                   negative,
   output logic                   zero,
   output logic                   cout,
   output logic                   overflow
);

   // Index of the first (largest) stage.
   localparam logic [SHIFT_WIDTH-1:0] K_FIRST = SHIFT_WIDTH'(SHIFT_WIDTH - 1);

   norm_state_t            state_r;
   logic [WIDTH-1:0]       v_r;        // working value, never visible on y
   norm_mode_t             mode_r;
   logic [SHIFT_WIDTH-1:0] cnt_r;      // working count, never visible on count
   logic [SHIFT_WIDTH-1:0] k_r;

   logic                   hit;
   logic [WIDTH-1:0]       v_next;
   logic [SHIFT_WIDTH-1:0] cnt_next;

   norm_stage #(
      .WIDTH       (WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_stage (
      .v      (v_r),
      .k      (k_r),
      .sgn    (mode_r),
      .hit    (hit),
      .v_next (v_next)
   );

   // Each stage owns exactly one count bit: stage k contributes 2^k.
   always_comb begin
      cnt_next = cnt_r;
      if (hit) begin
         cnt_next[k_r] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= NORM_IDLE;
         v_r     <= '0;
         mode_r  <= NORM_UNSIGNED;
         cnt_r   <= '0;
         k_r     <= K_FIRST;
         y       <= '0;
         count   <= '0;
      end else begin
         case (state_r)
            NORM_IDLE, NORM_DONE: begin
               // Same acceptance in DONE allows back-to-back operation.
               if (start) begin
                  v_r     <= x;
                  mode_r  <= sgn;
                  cnt_r   <= '0;
                  k_r     <= K_FIRST;
                  state_r <= NORM_RUN;
               end else begin
                  state_r <= NORM_IDLE;
               end
            end

            NORM_RUN: begin
               // start is deliberately not looked at while running.
               v_r   <= v_next;
               cnt_r <= cnt_next;
               if (k_r == '0) begin
                  // Results are published only here, so y/count never show
                  // partial values during a run.
                  y       <= v_next;
                  count   <= cnt_next;
                  state_r <= NORM_DONE;
               end else begin
                  k_r <= k_r - 1'b1;
               end
            end

            default: begin
               state_r <= NORM_IDLE;
            end
         endcase
      end
   end

   assign busy     = (state_r == NORM_RUN);
   assign done     = (state_r == NORM_DONE);

   assign negative = y[WIDTH-1];
   assign zero     = ~|y;
   assign cout     = 1'b0;
   assign overflow = 1'b0;

endmodule : norm_seq

// File: tb/tb_norm_seq.sv
// -----------------------------------------------------------------------------
// tb_norm_seq
//
// Self-checking bench for norm_seq (WIDTH=16). Each accepted operation pushes
// its expected result, computed by a bit-serial reference model, onto a
// scoreboard queue; a monitor pops and compares whenever done is sampled high.
// Directed sequences check latency, busy, held outputs, ignored starts,
// back-to-back operation and reset mid-run.
// -----------------------------------------------------------------------------
module tb_norm_seq;

   localparam int W  = 16;
   localparam int SW = 4;

   typedef struct {
      logic [W-1:0]  y;
      logic [SW-1:0] count;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  x;
   logic          sgn;
   logic          busy;
   logic          done;
   logic [W-1:0]  y;
   logic [SW-1:0] count;
   logic          negative;
   logic          zero;
   logic          cout;
   logic          overflow;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   norm_seq #(.WIDTH(W), .SHIFT_WIDTH(SW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .x        (x),
      .sgn      (sgn),
      .busy     (busy),
      .done     (done),
      .y        (y),
      .count    (count),
      .negative (negative),
      .zero     (zero),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: shift left one bit at a time while the value is not yet
   // normalized, stopping after W-1 shifts.
   function automatic exp_t model(input logic [W-1:0] xv, input logic s);
      exp_t e;
      e.y     = xv;
      e.count = '0;
      for (int i = 0; i < W - 1; i++) begin
         if (s ? (e.y[W-1] == e.y[W-2]) : !e.y[W-1]) begin
            e.y     = e.y << 1;
            e.count = e.count + 1'b1;
         end else begin
            break;
         end
      end
      return e;
   endfunction

   // Advance to just after the next rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("y",        32'(y),        32'(e.y));
            check("count",    32'(count),    32'(e.count));
            check("negative", 32'(negative), 32'(e.y[W-1]));
            check("zero",     32'(zero),     32'(e.y == '0));
            check("cout",     32'(cout),     32'd0);
            check("overflow", 32'(overflow), 32'd0);
         end
      end
   end

   // Start one operation from the current cycle (IDLE or DONE) and return in
   // its done cycle. Checks busy during the run and the latency to done.
   task automatic run_op(input logic [W-1:0] xv, input logic s);
      int n;
      exp_q.push_back(model(xv, s));
      start = 1'b1;
      x     = xv;
      sgn   = s;
      cycle();
      start = 1'b0;
      x     = W'($urandom);      // later changes must not matter
      sgn   = ~s;
      n     = 1;
      while (!done && n < 20) begin
         check("busy_run", 32'(busy), 32'd1);
         cycle();
         n++;
      end
      check("latency", 32'(n), 32'(SW + 1));
      check("busy_done", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [W-1:0] prev_y;
      logic [SW-1:0] prev_cnt;
      bit seen_done;

      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      sgn   = 1'b0;
      cycle();
      cycle();

      // Reset state
      check("rst_busy",  32'(busy),     32'd0);
      check("rst_done",  32'(done),     32'd0);
      check("rst_y",     32'(y),        32'd0);
      check("rst_count", 32'(count),    32'd0);
      check("rst_zero",  32'(zero),     32'd1);
      check("rst_neg",   32'(negative), 32'd0);
      rst = 1'b0;
      cycle();

      // Unsigned 0001: also confirm y/count stay at old values during run.
      exp_q.push_back(model(16'h0001, 1'b0));
      start = 1'b1;
      x     = 16'h0001;
      sgn   = 1'b0;
      cycle();
      start = 1'b0;
      for (int c = 1; c <= SW; c++) begin
         check("busy_c1_4", 32'(busy),  32'd1);
         check("done_c1_4", 32'(done),  32'd0);
         check("y_hidden",  32'(y),     32'd0);
         check("cnt_hidden", 32'(count), 32'd0);
         cycle();
      end
      check("done_c5", 32'(done), 32'd1);
      check("busy_c5", 32'(busy), 32'd0);
      cycle();
      check("done_pulse", 32'(done), 32'd0);

      // Directed operands from IDLE
      run_op(16'h00F0, 1'b0); cycle();
      run_op(16'h8000, 1'b0); cycle();
      run_op(16'h0003, 1'b1); cycle();
      run_op(16'hFFF0, 1'b1); cycle();
      run_op(16'hFFFF, 1'b1); cycle();
      run_op(16'h0000, 1'b1); cycle();

      // Unsigned zero with start pulses in cycles 2 and 3 that must be ignored
      exp_q.push_back(model(16'h0000, 1'b0));
      start = 1'b1;
      x     = 16'h0000;
      sgn   = 1'b0;
      cycle();                   // cycle 1
      start = 1'b0;
      cycle();                   // cycle 2
      start = 1'b1;
      x     = 16'hFFFF;
      sgn   = 1'b1;
      cycle();                   // cycle 3
      cycle();                   // cycle 4
      start = 1'b0;
      check("ign_busy_c4", 32'(busy), 32'd1);
      cycle();                   // cycle 5
      check("ign_done_c5", 32'(done), 32'd1);
      cycle();
      check("ign_no_restart", 32'(busy), 32'd0);
      cycle();

      // Back-to-back: second start issued in the done cycle of the first
      run_op(16'h00F0, 1'b0);
      prev_y   = y;
      prev_cnt = count;
      exp_q.push_back(model(16'h0100, 1'b0));
      start = 1'b1;
      x     = 16'h0100;
      sgn   = 1'b0;
      cycle();
      start = 1'b0;
      for (int c = 1; c <= SW; c++) begin
         check("b2b_busy",      32'(busy),  32'd1);
         check("b2b_y_held",    32'(y),     32'h0000F000);
         check("b2b_cnt_held",  32'(count), 32'(prev_cnt));
         cycle();
      end
      check("b2b_done", 32'(done), 32'd1);
      check("b2b_y_prev_nonzero", 32'(prev_y != y), 32'd1);
      cycle();

      // Random operations, a mix of idle gaps and back-to-back
      for (int i = 0; i < 16; i++) begin
         logic [W-1:0] rx;
         rx = W'($urandom) >> $urandom_range(0, W - 1);
         run_op(rx, 1'($urandom));
         if ($urandom_range(0, 1) == 0) cycle();
      end
      cycle();
      cycle();

      // Reset in cycle 2 of a run: abandon without a done pulse
      run_op(16'h0100, 1'b0);    // leaves a nonzero y behind
      cycle();
      start = 1'b1;
      x     = 16'h0001;
      sgn   = 1'b0;
      cycle();                   // cycle 1
      start = 1'b0;
      cycle();                   // cycle 2
      rst = 1'b1;
      cycle();                   // cycle 3, reset taken
      rst = 1'b0;
      check("mid_rst_busy",  32'(busy),  32'd0);
      check("mid_rst_done",  32'(done),  32'd0);
      check("mid_rst_y",     32'(y),     32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_zero",  32'(zero),  32'd1);
      seen_done = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (done) seen_done = 1'b1;
         cycle();
      end
      check("mid_rst_no_done", 32'(seen_done), 32'd0);

      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_norm_seq
